// File: rtl/crc8_pkg.sv
// Shared definitions for the CRC8 feeder and its engine-side models.
// Word/count widths and the feeder FSM state encoding.
package crc8_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 9;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_ACK,
    WAIT_IDLE,
    DONE
  } feeder_state_e;

endpackage

// File: rtl/sync_fifo_w16.sv
// Synchronous single-clock FIFO of 16-bit words with exact occupancy.
// The head word is visible combinationally; pop advances it on the next edge.
module sync_fifo_w16
  import crc8_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WORD_W-1:0]        push_data,
  input  logic                     pop,
  output logic [WORD_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // A pop frees a slot in the same cycle, so a write into a full FIFO succeeds then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign head  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and level alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/crc8_word_feeder.sv
// Buffers message words and streams one frame at a time into the CRC8 engine
// over its start/busy handshake, flagging overflow, bad length and ack timeout.
module crc8_word_feeder
  import crc8_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WORD_W-1:0]      wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  input  logic                   frame_go,
  input  logic [CNT_W-1:0]       frame_len,
  output logic                   frame_busy,
  output logic                   frame_done,
  output logic                   err_ovf,
  output logic                   err_len,
  output logic                   err_tmo,
  output logic [WORD_W-1:0]      crc_data,
  output logic                   crc_start,
  output logic [CNT_W-1:0]       crc_count,
  input  logic                   crc_busy
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  feeder_state_e     state;
  feeder_state_e     state_nxt;
  logic [CNT_W-1:0]  len;
  logic [CNT_W-1:0]  sent;
  logic [TW-1:0]     timer;
  logic              fifo_pop;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_head;
  logic              go_ok;
  logic              ack_expired;

  sync_fifo_w16 #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign go_ok       = (state == IDLE) && frame_go && (frame_len != '0);
  assign ack_expired = (state == WAIT_ACK) && !crc_busy && (timer == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (go_ok) state_nxt = FETCH;
      FETCH:     if (!fifo_empty) state_nxt = ISSUE;
      ISSUE:     if (!crc_busy) state_nxt = WAIT_ACK;
      WAIT_ACK:  if (crc_busy) state_nxt = WAIT_IDLE;
                 else if (ack_expired) state_nxt = IDLE;
      WAIT_IDLE: if (!crc_busy) state_nxt = (sent == len) ? DONE : FETCH;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    fifo_pop   = 1'b0;
    crc_start  = 1'b0;
    frame_done = 1'b0;
    frame_busy = (state != IDLE);
    case (state)
      FETCH:   fifo_pop   = !fifo_empty;
      ISSUE:   crc_start  = !crc_busy;
      DONE:    frame_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len       <= '0;
      sent      <= '0;
      timer     <= '0;
      crc_data  <= '0;
      crc_count <= '0;
      err_ovf   <= 1'b0;
      err_len   <= 1'b0;
      err_tmo   <= 1'b0;
    end else begin
      err_ovf <= wr_en && full && !fifo_pop;
      err_len <= (state == IDLE) && frame_go && (frame_len == '0);
      err_tmo <= ack_expired;
      case (state)
        IDLE: if (go_ok) begin
          len       <= frame_len;
          crc_count <= frame_len;
          sent      <= '0;
        end
        FETCH:    if (fifo_pop) crc_data <= fifo_head;
        ISSUE:    timer <= '0;
        WAIT_ACK: if (crc_busy) sent <= sent + 1'b1;
                  else timer <= timer + 1'b1;
        default:  ;
      endcase
    end
  end

endmodule

// File: doc/crc8_word_feeder.md
Name: crc8_word_feeder

Overview:
- Upstream stage of the CRC8 engine. Buffers 16-bit message words from a producer in a small FIFO.
- On command, streams one frame of N words into the engine using the engine's start/busy handshake, one word per engine transaction.
- Holds the word count stable for the whole frame and signals frame completion once the engine has gone idle after the last word. At that point the engine's CRC result is valid.

Parameters:
- DEPTH, 16, FIFO depth in words; power of two, 4..256.
- ACK_TIMEOUT, 4, max cycles from start pulse to busy rising before a timeout error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  push wr_data into FIFO.
- wr_data  in  16  message word.
- full  out  1  FIFO full.
- level  out  log2(DEPTH)+1  FIFO occupancy.
- frame_go  in  1  one-cycle command to send a frame.
- frame_len  in  9  words in frame, sampled when frame_go is accepted.
- frame_busy  out  1  frame in progress (state != IDLE).
- frame_done  out  1  one-cycle pulse when frame complete.
- err_ovf  out  1  one-cycle pulse: write dropped because FIFO full.
- err_len  out  1  one-cycle pulse: frame_go with frame_len==0.
- err_tmo  out  1  one-cycle pulse: engine did not acknowledge.
- crc_data  out  16  word presented to engine.
- crc_start  out  1  one-cycle start pulse to engine.
- crc_count  out  9  frame length presented to engine.
- crc_busy  in  1  engine busy.

Behaviour:
- Reset (async, immediate): state=IDLE, FIFO empty, all outputs 0, internal counters 0.
- FIFO:
  - Synchronous write and read.
  - Write while full is dropped and pulses err_ovf. A simultaneous read and write when full is allowed; the write succeeds.
  - level is exact every cycle.
  - Pointers wrap modulo DEPTH.
- Frame commands:
  - frame_go is accepted only in IDLE. frame_go while frame_busy is ignored, with no error.
  - frame_len==0 in IDLE: pulse err_len next cycle, stay IDLE.
  - On acceptance: latch len=frame_len; drive crc_count=frame_len, held constant until the next acceptance; sent=0; go to FETCH.
- FETCH: if FIFO is non-empty, pop the head into crc_data (registered) and go to ISSUE. If empty, stall in FETCH indefinitely (no error); frame_busy stays 1.
- ISSUE: only when crc_busy==0, assert crc_start for exactly one cycle, clear the ack timer, go to WAIT_ACK. If crc_busy==1, wait.
- WAIT_ACK:
  - crc_busy==1 → sent=sent+1, go to WAIT_IDLE.
  - Otherwise increment the timer. When timer==ACK_TIMEOUT, pulse err_tmo, flush nothing, go IDLE. The frame is abandoned and remaining words stay in the FIFO.
- WAIT_IDLE: on crc_busy==0, if sent==len go to DONE, else go to FETCH.
- DONE: frame_done=1 for one cycle, go IDLE.
- crc_start is never asserted in consecutive cycles, and never while crc_busy==1.
- crc_data is stable from the ISSUE cycle until the next FETCH pop.
- Latency: a word at the FIFO head when frame_go is accepted gives crc_start 2 cycles later (FETCH, ISSUE). frame_done comes 1 cycle after crc_busy falls on the last word.
- Writes are accepted in every state, including mid-frame.
- Reset mid-frame aborts immediately with no frame_done. The engine is reset by the same rst.

Decomposition:
- Shared package crc8_pkg:
  - word width 16 and count width 9 constants;
  - feeder state enum (IDLE, FETCH, ISSUE, WAIT_ACK, WAIT_IDLE, DONE), also used by the engine-side bench model.
- One sub-module, sync_fifo_w16: parameter DEPTH; ports for push, pop, data, full, empty, level.
- The FSM and timer live in the top module.

Test Plan:
- Single word. Push 0xA5A5, frame_go with frame_len=1, engine stub busy for 3 cycles. Required: one crc_start with crc_data=0xA5A5 and crc_count=1; frame_done 1 cycle after busy falls; frame_busy back to 0.
- Three words. Push 0x0001, 0x1234, 0xFFFF, frame_len=3. Required: exactly 3 starts in FIFO order; no start while busy=1; crc_count=3 throughout; one frame_done; level returns to 0.
- Underflow stall. frame_len=2 with one word queued. Required: stalls in FETCH after the first word. Push 0xBEEF 10 cycles later; second start carries 0xBEEF; frame_done follows.
- Overflow. With DEPTH=16, push 17 words with no frame. Required: full=1 after 16, one err_ovf on the 17th, level=16. Then push and pop in the same cycle while full: level stays 16.
- Errors. frame_go with frame_len=0 → err_len pulse, no start. With the stub never raising busy, frame_len=1 → err_tmo after ACK_TIMEOUT=4 cycles in WAIT_ACK, return to IDLE, word consumed.
- Async reset. Assert rst mid-frame in WAIT_IDLE. Required: all outputs 0 immediately, without waiting for a clk edge; level=0; no frame_done.
